// File: rtl/otter_pkg.sv
// +--------------------------------------------------------------------------+
// | otter_pkg : shared opcode, CSR func3 and control-FSM state encodings      |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package otter_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_RG3    = 7'b0110011,
    OP_SYS    = 7'b1110011
  } opcode_t;

  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;
  localparam logic [2:0] F3_CSRRS = 3'b010;
  localparam logic [2:0] F3_CSRRC = 3'b011;

  typedef enum logic [2:0] {
    ST_FETCH      = 3'd0,
    ST_FETCH_WAIT = 3'd1,
    ST_EXEC       = 3'd2,
    ST_LOAD_WAIT  = 3'd3,
    ST_INTR       = 3'd4
  } state_t;

  function automatic logic is_csr_op(input logic [2:0] f3);
    return (f3 == F3_CSRRW) || (f3 == F3_CSRRS) || (f3 == F3_CSRRC);
  endfunction

endpackage

`default_nettype wire

// File: rtl/otter_lat_cnt.sv
// +--------------------------------------------------------------------------+
// | otter_lat_cnt : memory-latency countdown (load, saturating decrement,    |
// |                 zero flag)                                               |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module otter_lat_cnt #(
  parameter int MEM_LAT = 1,
  localparam int CNT_W  = $clog2(MEM_LAT) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/otter_cu_fsm.sv
// +--------------------------------------------------------------------------+
// | otter_cu_fsm : OTTER multicycle control unit with variable memory latency|
// | Option       : define OTTER_CU_INTR_EN to enable interrupt entry         |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module otter_cu_fsm
  import otter_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       INTR,
  output logic       PC_WRITE,
  output logic       REG_WRITE,
  output logic       MEM_RDEN1,
  output logic       MEM_RDEN2,
  output logic       MEM_WE2,
  output logic       CSR_WE,
  output logic       INT_TAKEN,
  output logic       MRET_EXEC,
  output logic       ILL_INSTR
);

  localparam int CNT_W = $clog2(MEM_LAT) + 1;
  localparam logic [CNT_W-1:0] c_FETCH_WAIT_LD = (MEM_LAT > 1) ? CNT_W'(MEM_LAT - 2) : '0;
  localparam logic [CNT_W-1:0] c_LOAD_WAIT_LD  = CNT_W'(MEM_LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_zero;
  logic             w_intr;

`ifdef OTTER_CU_INTR_EN
  assign w_intr = INTR;
`else
  logic w_unused_intr;
  assign w_unused_intr = INTR;
  assign w_intr        = 1'b0;
`endif

  otter_lat_cnt #(.MEM_LAT(MEM_LAT)) u_lat_cnt (
    .clk     (CLK),
    .rst     (RST),
    .i_load  (w_cnt_load),
    .i_value (w_cnt_val),
    .i_dec   (w_cnt_dec),
    .o_zero  (w_cnt_zero)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    w_cnt_val  = '0;
    case (r_state)
      ST_FETCH: begin
        if (MEM_LAT == 1) begin
          w_next = ST_EXEC;
        end else begin
          w_next     = ST_FETCH_WAIT;
          w_cnt_load = 1'b1;
          w_cnt_val  = c_FETCH_WAIT_LD;
        end
      end
      ST_FETCH_WAIT: begin
        if (w_cnt_zero) w_next = ST_EXEC;
        else            w_cnt_dec = 1'b1;
      end
      ST_EXEC: begin
        if (opcode == OP_LOAD) begin
          w_next     = ST_LOAD_WAIT;
          w_cnt_load = 1'b1;
          w_cnt_val  = c_LOAD_WAIT_LD;
        end else begin
          // An mret retires here; a pending interrupt is taken on the next cycle.
          w_next = w_intr ? ST_INTR : ST_FETCH;
        end
      end
      ST_LOAD_WAIT: begin
        if (w_cnt_zero) w_next = w_intr ? ST_INTR : ST_FETCH;
        else            w_cnt_dec = 1'b1;
      end
      ST_INTR: w_next = ST_FETCH;
      default: w_next = ST_FETCH;
    endcase
  end

  always_comb begin
    PC_WRITE  = 1'b0;
    REG_WRITE = 1'b0;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    CSR_WE    = 1'b0;
    INT_TAKEN = 1'b0;
    MRET_EXEC = 1'b0;
    ILL_INSTR = 1'b0;
    if (!RST) begin
      case (r_state)
        ST_FETCH: MEM_RDEN1 = 1'b1;
        ST_EXEC: begin
          case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_RG3: begin
              REG_WRITE = 1'b1;
              PC_WRITE  = 1'b1;
            end
            OP_BRANCH: PC_WRITE = 1'b1;
            OP_STORE: begin
              MEM_WE2  = 1'b1;
              PC_WRITE = 1'b1;
            end
            OP_LOAD: MEM_RDEN2 = 1'b1;
            OP_SYS: begin
              PC_WRITE = 1'b1;
              if (is_csr_op(func3)) begin
                CSR_WE    = 1'b1;
                REG_WRITE = 1'b1;
              end else if (func3 == F3_MRET) begin
                MRET_EXEC = 1'b1;
              end
            end
            default: begin
              ILL_INSTR = 1'b1;
              PC_WRITE  = 1'b1;
            end
          endcase
        end
        ST_LOAD_WAIT: begin
          if (w_cnt_zero) begin
            REG_WRITE = 1'b1;
            PC_WRITE  = 1'b1;
          end
        end
`ifdef OTTER_CU_INTR_EN
        ST_INTR: begin
          INT_TAKEN = 1'b1;
          PC_WRITE  = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_otter_cu_fsm.sv
// +--------------------------------------------------------------------------+
// | tb_otter_cu_fsm : self-checking bench, three latencies (1, 3, 4) in      |
// |                   parallel; honours OTTER_CU_INTR_EN                     |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_otter_cu_fsm;

`ifdef OTTER_CU_INTR_EN
  localparam bit INTR_EN = 1'b1;
`else
  localparam bit INTR_EN = 1'b0;
`endif

  localparam logic [8:0] B_PCW  = 9'h100;
  localparam logic [8:0] B_RW   = 9'h080;
  localparam logic [8:0] B_RD1  = 9'h040;
  localparam logic [8:0] B_RD2  = 9'h020;
  localparam logic [8:0] B_WE2  = 9'h010;
  localparam logic [8:0] B_CSR  = 9'h008;
  localparam logic [8:0] B_INT  = 9'h004;
  localparam logic [8:0] B_MRET = 9'h002;
  localparam logic [8:0] B_ILL  = 9'h001;

  localparam int LAT [3] = '{1, 3, 4};

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [6:0] opcode = 7'b0010011;
  logic [2:0] func3 = 3'b000;
  logic       INTR = 1'b0;

  logic [8:0] o0, o1, o2;
  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 CLK = ~CLK;

  otter_cu_fsm #(.MEM_LAT(1)) dut0 (
    .CLK(CLK), .RST(RST), .opcode(opcode), .func3(func3), .INTR(INTR),
    .PC_WRITE(o0[8]), .REG_WRITE(o0[7]), .MEM_RDEN1(o0[6]), .MEM_RDEN2(o0[5]),
    .MEM_WE2(o0[4]), .CSR_WE(o0[3]), .INT_TAKEN(o0[2]), .MRET_EXEC(o0[1]), .ILL_INSTR(o0[0]));
  otter_cu_fsm #(.MEM_LAT(3)) dut1 (
    .CLK(CLK), .RST(RST), .opcode(opcode), .func3(func3), .INTR(INTR),
    .PC_WRITE(o1[8]), .REG_WRITE(o1[7]), .MEM_RDEN1(o1[6]), .MEM_RDEN2(o1[5]),
    .MEM_WE2(o1[4]), .CSR_WE(o1[3]), .INT_TAKEN(o1[2]), .MRET_EXEC(o1[1]), .ILL_INSTR(o1[0]));
  otter_cu_fsm #(.MEM_LAT(4)) dut2 (
    .CLK(CLK), .RST(RST), .opcode(opcode), .func3(func3), .INTR(INTR),
    .PC_WRITE(o2[8]), .REG_WRITE(o2[7]), .MEM_RDEN1(o2[6]), .MEM_RDEN2(o2[5]),
    .MEM_WE2(o2[4]), .CSR_WE(o2[3]), .INT_TAKEN(o2[2]), .MRET_EXEC(o2[1]), .ILL_INSTR(o2[0]));

  // Instruction timeline model: cycle 0 fetch, cycle L execute, loads
  // write back at cycle 2L, an optional interrupt cycle after the last one.
  int pos     [3];
  bit ld      [3];
  bit in_intr [3];

  function automatic logic [8:0] exp_exec(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011, 7'b0110011:
        return B_RW | B_PCW;
      7'b1100011: return B_PCW;
      7'b0100011: return B_WE2 | B_PCW;
      7'b0000011: return B_RD2;
      7'b1110011: begin
        if (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3) return B_CSR | B_RW | B_PCW;
        else if (f3 == 3'd0)                        return B_MRET | B_PCW;
        else                                        return B_PCW;
      end
      default: return B_ILL | B_PCW;
    endcase
  endfunction

  function automatic logic [8:0] model_out(input int i);
    if (RST)                          return 9'h000;
    if (in_intr[i])                   return B_INT | B_PCW;
    if (pos[i] == 0)                  return B_RD1;
    if (pos[i] < LAT[i])              return 9'h000;
    if (pos[i] == LAT[i])             return exp_exec(opcode, func3);
    if (ld[i] && pos[i] == 2*LAT[i])  return B_RW | B_PCW;
    return 9'h000;
  endfunction

  always @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (RST) begin
        pos[i] = 0; ld[i] = 1'b0; in_intr[i] = 1'b0;
      end else if (in_intr[i]) begin
        in_intr[i] = 1'b0; pos[i] = 0;
      end else if (pos[i] == LAT[i] && opcode == 7'b0000011) begin
        ld[i] = 1'b1; pos[i] = pos[i] + 1;
      end else if ((pos[i] == LAT[i] && !ld[i]) || (ld[i] && pos[i] == 2*LAT[i])) begin
        ld[i] = 1'b0; pos[i] = 0;
        in_intr[i] = INTR_EN && INTR;
      end else begin
        pos[i] = pos[i] + 1;
      end
    end
  end

  logic [8:0] lg [3][64];
  int cyc = 0;

  always @(negedge CLK) begin
    logic [8:0] act [3];
    logic [8:0] e;
    act[0] = o0; act[1] = o1; act[2] = o2;
    for (int i = 0; i < 3; i++) begin
      e = model_out(i);
      vec_cnt++;
      if (act[i] !== e) begin
        err_cnt++;
        $display("FAIL cycle_out L=%0d cyc=%0d op=%b f3=%b intr=%b: got %b expected %b",
                 LAT[i], cyc, opcode, func3, INTR, act[i], e);
      end
    end
    if (RST) begin
      cyc = 0;
    end else begin
      if (cyc < 64) begin
        for (int i = 0; i < 3; i++) lg[i][cyc] = act[i];
      end
      cyc++;
    end
  end

  task automatic lit(input string name, input logic [8:0] act, input logic [8:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
  endtask

  logic [10:0] tbl [18];
  int          icnt;

  initial begin
    tbl = '{
      {7'b0010011, 3'd0, 1'b0}, {7'b0110111, 3'd0, 1'b0}, {7'b0010111, 3'd5, 1'b1},
      {7'b1101111, 3'd0, 1'b0}, {7'b1100111, 3'd0, 1'b1}, {7'b0110011, 3'd7, 1'b0},
      {7'b1100011, 3'd1, 1'b0}, {7'b0100011, 3'd2, 1'b1}, {7'b0000011, 3'd2, 1'b0},
      {7'b0000011, 3'd4, 1'b1}, {7'b1110011, 3'd1, 1'b0}, {7'b1110011, 3'd2, 1'b1},
      {7'b1110011, 3'd3, 1'b0}, {7'b1110011, 3'd0, 1'b1}, {7'b1110011, 3'd4, 1'b0},
      {7'b1111111, 3'd0, 1'b0}, {7'b0000000, 3'd6, 1'b1}, {7'b0010011, 3'd0, 1'b0}
    };

    // L=1 OP_IMM: fetch, execute, fetch.
    opcode = 7'b0010011; func3 = 3'd0; INTR = 1'b0;
    run(3); RST = 1'b0; run(10);
    lit("opimm_c0", lg[0][0], B_RD1);
    lit("opimm_c1", lg[0][1], B_RW | B_PCW);
    lit("opimm_c2", lg[0][2], B_RD1);

    // L=3 LOAD: 7-cycle instruction.
    opcode = 7'b0000011;
    do_reset(); run(10);
    lit("load3_c0", lg[1][0], B_RD1);
    lit("load3_c1", lg[1][1], 9'h000);
    lit("load3_c3", lg[1][3], B_RD2);
    lit("load3_c5", lg[1][5], 9'h000);
    lit("load3_c6", lg[1][6], B_RW | B_PCW);
    lit("load3_c7", lg[1][7], B_RD1);

    // STORE with interrupt pending.
    opcode = 7'b0100011; INTR = 1'b1;
    do_reset(); run(6);
    lit("store_c1", lg[0][1], B_WE2 | B_PCW);
    lit("store_c2", lg[0][2], INTR_EN ? (B_INT | B_PCW) : B_RD1);
    lit("store_c3", lg[0][3], INTR_EN ? B_RD1 : (B_WE2 | B_PCW));

    // 20 instructions with INTR held high (3 cycles each when enabled).
    opcode = 7'b0010011;
    do_reset(); run(60);
    icnt = 0;
    for (int c = 0; c < 60; c++) if (lg[0][c][2]) icnt++;
    lit("int_taken_count", 9'(icnt), INTR_EN ? 9'd20 : 9'd0);
    INTR = 1'b0;

    opcode = 7'b1110011; func3 = 3'd1;
    do_reset(); run(3);
    lit("csrrw", lg[0][1], B_CSR | B_RW | B_PCW);
    func3 = 3'd0;
    do_reset(); run(3);
    lit("mret", lg[0][1], B_MRET | B_PCW);
    opcode = 7'b1111111;
    do_reset(); run(3);
    lit("illegal", lg[0][1], B_ILL | B_PCW);

    // Reset in the middle of an L=4 load wait.
    opcode = 7'b0000011; func3 = 3'd0;
    do_reset(); run(6);
    lit("rstld_c4_rden2", lg[2][4], B_RD2);
    RST = 1'b1;
    #2;
    lit("rst_hold_l1", o0, 9'h000);
    lit("rst_hold_l3", o1, 9'h000);
    lit("rst_hold_l4", o2, 9'h000);
    run(2);
    RST = 1'b0;
    run(4);
    lit("rstld_rel_c0", lg[2][0], B_RD1);
    lit("rstld_rel_c1", lg[2][1], 9'h000);
    lit("rstld_rel_c3", lg[2][3], 9'h000);

    // Sweep of every opcode class with interrupts interleaved.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      {opcode, func3, INTR} = tbl[k];
      run(24);
    end
    INTR = 1'b0;
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
